countdown_timer: RTL
====================

Name: countdown_timer

Overview:
Down-counting MM:SS timer. It loads a preset time, counts down once per tick under start/pause control, and flags expiry at 00:00. It is the count-down counterpart to the stopwatch: same min/sec format with values 0-59, and the same button semantics. It sits beside the stopwatch and feeds the same display path, with an added expiry output for an alarm or LED.

Parameters:
TICK_DIV, 1, clock cycles per one-second tick (1 = decrement on every running clock, for simulation); must be >= 1
WIDTH, 6, bit width of the min and sec fields
MAX_VALUE, 59, maximum value of each field; also the seconds reload value on a minute borrow

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
load  input  1  one-cycle strobe; captures load_min/load_sec
load_min  input  WIDTH  preset minutes
load_sec  input  WIDTH  preset seconds
start  input  1  start/resume request (level sampled each clock, already debounced)
pause  input  1  pause request (level sampled each clock)
min  output  WIDTH  remaining minutes, registered
sec  output  WIDTH  remaining seconds, registered
running  output  1  high while in RUNNING state
done  output  1  level; high while in EXPIRED state
done_pulse  output  1  single-cycle strobe on the transition into EXPIRED

Behaviour:
- FSM states: IDLE, RUNNING, PAUSED, EXPIRED. All outputs are registered.
- Reset (rst=1 at edge):
  - state=IDLE, min=0, sec=0, prescaler=0
  - running=0, done=0, done_pulse=0
  - Reset overrides every other input and applies mid-count.
- Priority per edge: rst > load > pause > start.
- load:
  - Accepted in IDLE, PAUSED and EXPIRED; ignored in RUNNING.
  - Each field >MAX_VALUE is clamped to MAX_VALUE.
  - Next state IDLE; prescaler=0; done=0.
  - A start in the same cycle is ignored.
- start:
  - IDLE or PAUSED with time != 00:00 -> RUNNING.
  - IDLE with 00:00 -> stays IDLE (no expiry, no done_pulse).
  - Ignored in RUNNING and EXPIRED.
- pause:
  - RUNNING -> PAUSED; the prescaler value is held, not cleared.
  - No effect in other states.
  - start and pause asserted together: pause wins (RUNNING->PAUSED; IDLE/PAUSED unchanged).
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUNNING.
  - tick=1 in the cycle where prescaler==TICK_DIV-1; it then wraps to 0.
  - With TICK_DIV=1, tick is asserted on every RUNNING cycle.
- Decrement on tick:
  - sec>0: sec-1.
  - sec==0 and min>0: sec=MAX_VALUE, min-1.
  - The result is written at the same edge.
- Expiry:
  - If a tick makes the time 00:00 (the previous value was 00:01), then at that same edge: state=EXPIRED, running=0, done=1, done_pulse=1.
  - done_pulse clears on the following edge.
  - EXPIRED holds 00:00 and done=1 until load or rst.
- Latency: start sampled at edge N -> running=1 after edge N. With TICK_DIV=1 the first decrement is visible after edge N+1.
- Wrap-around: the counter never underflows below 00:00 and never counts up.

Test Plan:
1. Reset mid-run: load 05:30, start, run 10 cycles (TICK_DIV=1), assert rst -> next edge min=0, sec=0, running=0, done=0, state IDLE.
2. Basic expiry (TICK_DIV=1): load 00:03, start at edge N -> sec=2,1,0 after edges N+1..N+3. At N+3: done=1, done_pulse=1, running=0. At N+4: done_pulse=0, done=1, sec stays 0.
3. Minute borrow: load 02:00, start, one tick -> min=1, sec=59. After 119 total ticks -> 00:01; after 120 -> expired.
4. Pause/resume with TICK_DIV=4: load 00:02, start, pause after 2 running cycles -> sec holds 2 for 20 cycles. Resume -> first decrement after 2 more running cycles (prescaler held).
5. Priorities and ignores:
   - start+pause together while RUNNING -> PAUSED.
   - load 01:00 while RUNNING -> ignored.
   - start with 00:00 in IDLE -> stays IDLE, done=0.
6. Clamp and reload from EXPIRED: in EXPIRED, load min=63, sec=60 -> min=59, sec=59, done=0, IDLE. Start -> counts down from 59:59.

Source files
------------

// File: rtl/countdown_timer.sv
// countdown_timer: down-counting MM:SS timer with load/start/pause control
// and an expiry flag. Counts down one second per prescaler tick while running
// and stops at 00:00.
//
// Ports:
//   clk, rst          - system clock, synchronous active-high reset
//   load              - one-cycle strobe capturing load_min/load_sec (clamped)
//   load_min/load_sec - preset time
//   start, pause      - level controls sampled each clock (pause wins)
//   min, sec          - remaining time, registered
//   running           - high while counting
//   done              - high while expired
//   done_pulse        - one-cycle strobe on entry to expired
module countdown_timer #(
   parameter int unsigned TICK_DIV  = 1,
   parameter int unsigned WIDTH     = 6,
   parameter int unsigned MAX_VALUE = 59
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_min,
   input  logic [WIDTH-1:0] load_sec,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] min,
   output logic [WIDTH-1:0] sec,
   output logic             running,
   output logic             done,
   output logic             done_pulse
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      PAUSED  = 2'd2,
      EXPIRED = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] min_q, min_d;
   logic [WIDTH-1:0] sec_q, sec_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic             running_q, running_d;
   logic             done_q, done_d;
   logic             done_pulse_q, done_pulse_d;

   logic [WIDTH-1:0] clamp_min, clamp_sec;
   logic             time_zero;
   logic             tick;

   assign clamp_min = (load_min > WIDTH'(MAX_VALUE)) ? WIDTH'(MAX_VALUE) : load_min;
   assign clamp_sec = (load_sec > WIDTH'(MAX_VALUE)) ? WIDTH'(MAX_VALUE) : load_sec;
   assign time_zero = (min_q == '0) && (sec_q == '0);
   assign tick      = (presc_q == PW'(TICK_DIV - 1));

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         min_q        <= '0;
         sec_q        <= '0;
         presc_q      <= '0;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         done_pulse_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         min_q        <= min_d;
         sec_q        <= sec_d;
         presc_q      <= presc_d;
         running_q    <= running_d;
         done_q       <= done_d;
         done_pulse_q <= done_pulse_d;
      end
   end

   // Next-state, time and output logic
   always_comb begin
      state_d      = state_q;
      min_d        = min_q;
      sec_d        = sec_q;
      presc_d      = presc_q;
      done_pulse_d = 1'b0;

      unique case (state_q)
         IDLE, PAUSED: begin
            if (load) begin
               min_d   = clamp_min;
               sec_d   = clamp_sec;
               presc_d = '0;
               state_d = IDLE;
            end else if (pause) begin
               state_d = state_q;
            end else if (start && !time_zero) begin
               state_d = RUNNING;
            end
         end
         RUNNING: begin
            // A pausing edge does not advance the prescaler; its value is kept.
            if (pause) begin
               state_d = PAUSED;
            end else if (tick) begin
               presc_d = '0;
               if (sec_q != '0) begin
                  sec_d = sec_q - WIDTH'(1);
               end else begin
                  sec_d = WIDTH'(MAX_VALUE);
                  min_d = min_q - WIDTH'(1);
               end
               // Only 00:01 can reach 00:00 on a tick.
               if ((min_q == '0) && (sec_q == WIDTH'(1))) begin
                  state_d      = EXPIRED;
                  done_pulse_d = 1'b1;
               end
            end else begin
               presc_d = presc_q + PW'(1);
            end
         end
         EXPIRED: begin
            if (load) begin
               min_d   = clamp_min;
               sec_d   = clamp_sec;
               presc_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      running_d = (state_d == RUNNING);
      done_d    = (state_d == EXPIRED);
   end

   assign min        = min_q;
   assign sec        = sec_q;
   assign running    = running_q;
   assign done       = done_q;
   assign done_pulse = done_pulse_q;

endmodule
